// File: rtl/mole_grid_renderer.sv
// mole_grid_renderer
// Draws a COLS x ROWS whack-a-mole grid onto a 640x480 pixel stream.
// Mole requests are latched once per frame so the picture never tears,
// accepted hits start a per-hole flash that counts down in frames, and
// the pixel path is a two-stage pipeline that advances on the pixel strobe.

module mole_grid_renderer #(
    parameter int COLS         = 3,
    parameter int ROWS         = 3,
    parameter int ORIGIN_X     = 100,
    parameter int ORIGIN_Y     = 60,
    parameter int CELL_W       = 80,
    parameter int CELL_H       = 80,
    parameter int PITCH_X      = 180,
    parameter int PITCH_Y      = 140,
    parameter int FLASH_FRAMES = 30,
    parameter int CENTER_SKIP  = 1,
    localparam int N           = COLS * ROWS
) (
    input  logic         CLK,
    input  logic         RST_BTN,
    input  logic         i_pix_stb,
    input  logic [9:0]   i_x,
    input  logic [8:0]   i_y,
    input  logic         i_active,
    input  logic         i_frame_start,
    input  logic [N-1:0] i_mole,
    input  logic [N-1:0] i_hit,
    output logic [N-1:0] o_hit_accepted,
    output logic [3:0]   VGA_R,
    output logic [3:0]   VGA_G,
    output logic [3:0]   VGA_B
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    // The centre marker only exists when the grid has a true centre hole.
    localparam bit SKIP_EN  = (CENTER_SKIP != 0) && ((COLS % 2) == 1) && ((ROWS % 2) == 1);
    localparam int CENTER_K = (ROWS / 2) * COLS + (COLS / 2);

    localparam logic [N-1:0]  CENTER_MASK = SKIP_EN ? (N'(1) << CENTER_K) : '0;
    localparam logic [KW-1:0] CENTER_IDX  = KW'(CENTER_K);
    localparam logic [FW-1:0] FLASH_LOAD  = FW'(FLASH_FRAMES);

    // Playfield bounding box, half-open on the high side.
    localparam logic [10:0] PF_X_LO = 11'(ORIGIN_X);
    localparam logic [10:0] PF_X_HI = 11'(ORIGIN_X + (COLS - 1) * PITCH_X + CELL_W);
    localparam logic [10:0] PF_Y_LO = 11'(ORIGIN_Y);
    localparam logic [10:0] PF_Y_HI = 11'(ORIGIN_Y + (ROWS - 1) * PITCH_Y + CELL_H);

    localparam logic [11:0] RGB_BLACK = 12'h000;
    localparam logic [11:0] RGB_GRID  = 12'hF00;
    localparam logic [11:0] RGB_MARK  = 12'h00F;
    localparam logic [11:0] RGB_HIT   = 12'hFF0;
    localparam logic [11:0] RGB_MOLE  = 12'h0F0;

    // ------------------------------------------------------------------
    // Hole state: latched moles, flash counters, hit pulses
    // ------------------------------------------------------------------
    logic [N-1:0]  mole_disp_reg;
    logic [FW-1:0] flash_reg [N];
    logic [N-1:0]  hit_pulse_reg;
    logic [N-1:0]  flash_nz;
    logic [N-1:0]  hit_accept;
    logic [N-1:0]  mole_next;

    // The centre bit is cleared at latch time so it can never be hit.
    assign mole_next = i_mole & ~CENTER_MASK;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_hole
            assign flash_nz[gi]   = (flash_reg[gi] != '0);
            // A hole takes a hit only while its mole is shown and it is not already flashing.
            assign hit_accept[gi] = i_hit[gi] & mole_disp_reg[gi] & ~flash_nz[gi];
        end
    endgenerate

    // Per-frame mole latch, flash countdown (load beats decrement) and hit pulses.
    always_ff @(posedge CLK) begin
        if (!RST_BTN) begin
            mole_disp_reg <= '0;
            hit_pulse_reg <= '0;
            for (int k = 0; k < N; k++) begin
                flash_reg[k] <= '0;
            end
        end else begin
            hit_pulse_reg <= hit_accept;
            if (i_frame_start) begin
                mole_disp_reg <= mole_next;
            end
            for (int k = 0; k < N; k++) begin
                if (hit_accept[k]) begin
                    flash_reg[k] <= FLASH_LOAD;
                end else if (i_frame_start && flash_nz[k]) begin
                    flash_reg[k] <= flash_reg[k] - 1'b1;
                end
            end
        end
    end

    assign o_hit_accepted = hit_pulse_reg;

    // ------------------------------------------------------------------
    // Stage 1 decode: compare-only column/row lookup
    // ------------------------------------------------------------------
    logic [10:0]     pix_x;
    logic [10:0]     pix_y;
    logic [COLS-1:0] col_match;
    logic [ROWS-1:0] row_match;

    assign pix_x = {1'b0, i_x};
    assign pix_y = {2'b00, i_y};

    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            localparam logic [10:0] C_LO = 11'(ORIGIN_X + gi * PITCH_X);
            localparam logic [10:0] C_HI = 11'(ORIGIN_X + gi * PITCH_X + CELL_W);
            assign col_match[gi] = (pix_x >= C_LO) && (pix_x < C_HI);
        end
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            localparam logic [10:0] R_LO = 11'(ORIGIN_Y + gi * PITCH_Y);
            localparam logic [10:0] R_HI = 11'(ORIGIN_Y + gi * PITCH_Y + CELL_H);
            assign row_match[gi] = (pix_y >= R_LO) && (pix_y < R_HI);
        end
    endgenerate

    logic [CW-1:0] col_idx_next;
    logic [RW-1:0] row_idx_next;
    logic          in_pf_next;
    logic          in_hole_next;

    // Encode the one-hot column/row matches; pitch >= cell size keeps them one-hot.
    always_comb begin
        col_idx_next = '0;
        row_idx_next = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col_match[c]) begin
                col_idx_next = CW'(c);
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            if (row_match[r]) begin
                row_idx_next = RW'(r);
            end
        end
        in_pf_next   = (pix_x >= PF_X_LO) && (pix_x < PF_X_HI) &&
                       (pix_y >= PF_Y_LO) && (pix_y < PF_Y_HI);
        in_hole_next = (|col_match) && (|row_match);
    end

    // ------------------------------------------------------------------
    // Stage 2: colour selection using hole state at stage-2 time
    // ------------------------------------------------------------------
    logic [CW-1:0] s1_col_reg;
    logic [RW-1:0] s1_row_reg;
    logic          s1_in_pf_reg;
    logic          s1_in_hole_reg;
    logic          s1_active_reg;
    logic [11:0]   colour_reg;
    logic [11:0]   colour_next;
    logic [KW-1:0] hole_k;

    assign hole_k = KW'(s1_row_reg * COLS + s1_col_reg);

    // Colour priority: blanking, outside, grid, centre marker, flash, mole.
    always_comb begin
        colour_next = RGB_BLACK;
        if (!s1_active_reg || !s1_in_pf_reg) begin
            colour_next = RGB_BLACK;
        end else if (!s1_in_hole_reg) begin
            colour_next = RGB_GRID;
        end else if (SKIP_EN && (hole_k == CENTER_IDX)) begin
            colour_next = RGB_MARK;
        end else if (flash_nz[hole_k]) begin
            colour_next = RGB_HIT;
        end else if (mole_disp_reg[hole_k]) begin
            colour_next = RGB_MOLE;
        end
    end

    // Pixel pipeline: both stages step together on each pixel strobe and hold otherwise.
    always_ff @(posedge CLK) begin
        if (!RST_BTN) begin
            s1_col_reg     <= '0;
            s1_row_reg     <= '0;
            s1_in_pf_reg   <= 1'b0;
            s1_in_hole_reg <= 1'b0;
            s1_active_reg  <= 1'b0;
            colour_reg     <= '0;
        end else if (i_pix_stb) begin
            s1_col_reg     <= col_idx_next;
            s1_row_reg     <= row_idx_next;
            s1_in_pf_reg   <= in_pf_next;
            s1_in_hole_reg <= in_hole_next;
            s1_active_reg  <= i_active;
            colour_reg     <= colour_next;
        end
    end

    assign VGA_R = colour_reg[11:8];
    assign VGA_G = colour_reg[7:4];
    assign VGA_B = colour_reg[3:0];

endmodule

// File: tb/tb_mole_grid_renderer.sv
// Self-checking bench for mole_grid_renderer: directed scenarios with
// hand-computed colours plus a randomized run, all compared every cycle
// against a behavioural model that decodes geometry with plain division.

module tb_mole_grid_renderer;

    localparam int COLS = 3;
    localparam int ROWS = 3;
    localparam int OX   = 100;
    localparam int OY   = 60;
    localparam int CWD  = 80;
    localparam int CHT  = 80;
    localparam int PX   = 180;
    localparam int PY   = 140;
    localparam int FF   = 30;
    localparam int N    = COLS * ROWS;
    localparam int CTR  = (ROWS / 2) * COLS + (COLS / 2);

    logic         CLK;
    logic         rst_n;
    logic         i_pix_stb;
    logic [9:0]   i_x;
    logic [8:0]   i_y;
    logic         i_active;
    logic         i_frame_start;
    logic [N-1:0] i_mole;
    logic [N-1:0] i_hit;
    logic [N-1:0] o_hit_accepted;
    logic [3:0]   VGA_R, VGA_G, VGA_B;

    mole_grid_renderer #(
        .COLS(COLS), .ROWS(ROWS), .ORIGIN_X(OX), .ORIGIN_Y(OY),
        .CELL_W(CWD), .CELL_H(CHT), .PITCH_X(PX), .PITCH_Y(PY),
        .FLASH_FRAMES(FF), .CENTER_SKIP(1)
    ) dut (
        .CLK(CLK), .RST_BTN(rst_n), .i_pix_stb(i_pix_stb), .i_x(i_x), .i_y(i_y),
        .i_active(i_active), .i_frame_start(i_frame_start), .i_mole(i_mole),
        .i_hit(i_hit), .o_hit_accepted(o_hit_accepted),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    bit [N-1:0] m_mole;
    int         m_flash [N];
    bit [N-1:0] m_acc;
    bit [11:0]  m_rgb;
    int         s1x, s1y;
    bit         s1a;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Colour of a pixel from the geometry rules, using the current hole state.
    function automatic bit [11:0] colour_of(int x, int y, bit a);
        int c, r, k;
        if (!a) return 12'h000;
        if (x < OX || x >= OX + (COLS - 1) * PX + CWD) return 12'h000;
        if (y < OY || y >= OY + (ROWS - 1) * PY + CHT) return 12'h000;
        if (((x - OX) % PX) >= CWD || ((y - OY) % PY) >= CHT) return 12'hF00;
        c = (x - OX) / PX;
        r = (y - OY) / PY;
        k = r * COLS + c;
        if (k == CTR) return 12'h00F;
        if (m_flash[k] > 0) return 12'hFF0;
        if (m_mole[k]) return 12'h0F0;
        return 12'h000;
    endfunction

    // Advance the model by one clock edge with the inputs that were applied.
    task automatic model_update();
        bit [N-1:0] acc;
        if (!rst_n) begin
            m_mole = '0;
            m_acc  = '0;
            m_rgb  = '0;
            s1x = 0; s1y = 0; s1a = 0;
            for (int k = 0; k < N; k++) m_flash[k] = 0;
            return;
        end
        for (int k = 0; k < N; k++) acc[k] = i_hit[k] && m_mole[k] && (m_flash[k] == 0);
        if (i_pix_stb) begin
            m_rgb = colour_of(s1x, s1y, s1a);
            s1x = int'(i_x); s1y = int'(i_y); s1a = i_active;
        end
        for (int k = 0; k < N; k++) begin
            if (acc[k]) m_flash[k] = FF;
            else if (i_frame_start && m_flash[k] > 0) m_flash[k] = m_flash[k] - 1;
        end
        if (i_frame_start) begin
            m_mole = i_mole;
            m_mole[CTR] = 1'b0;
        end
        m_acc = acc;
    endtask

    // One clock: sample after the edge, update the model, compare every cycle.
    task automatic tick();
        @(posedge CLK);
        #1;
        model_update();
        check("rgb", {VGA_R, VGA_G, VGA_B}, m_rgb);
        check("acc", o_hit_accepted, m_acc);
    endtask

    task automatic pulse_frame();
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
    endtask

    // Push one pixel through both stages and pin the result to a literal.
    task automatic show(int x, int y, bit a, logic [11:0] exp, string name);
        i_x = 10'(x); i_y = 9'(y); i_active = a; i_pix_stb = 1'b1;
        tick();
        tick();
        i_pix_stb = 1'b0;
        check(name, {VGA_R, VGA_G, VGA_B}, exp);
        check({name, "_model"}, m_rgb, exp);
        $display("[TB] pixel (%0d,%0d) act=%0d -> %03h (%s)", x, y, a, {VGA_R, VGA_G, VGA_B}, name);
    endtask

    task automatic hit(logic [N-1:0] h, bit with_frame, logic [N-1:0] exp, string name);
        i_hit = h; i_frame_start = with_frame;
        tick();
        i_hit = '0; i_frame_start = 1'b0;
        check(name, o_hit_accepted, exp);
        check({name, "_model"}, m_acc, exp);
        $display("[TB] hit %03h frame=%0d -> accepted %03h (%s)", h, with_frame, o_hit_accepted, name);
    endtask

    initial begin
        rst_n = 1'b0; i_pix_stb = 1'b0; i_x = '0; i_y = '0; i_active = 1'b0;
        i_frame_start = 1'b0; i_mole = '0; i_hit = '0;
        repeat (3) tick();
        check("reset_rgb", {VGA_R, VGA_G, VGA_B}, 12'h000);
        check("reset_acc", o_hit_accepted, '0);
        rst_n = 1'b1;
        tick();

        // Geometry with mole 0 latched
        i_mole = 9'h001;
        pulse_frame();
        show(120, 80, 1, 12'h0F0, "geo_mole0");
        show(200, 80, 1, 12'hF00, "geo_grid");
        show(320, 240, 1, 12'h00F, "geo_centre");
        show(539, 419, 1, 12'h000, "geo_last_in");
        show(540, 419, 1, 12'h000, "geo_right_out");
        show(50, 50, 1, 12'h000, "geo_outside");
        show(120, 80, 0, 12'h000, "geo_blank");

        // Frame latch: mole 8 only appears after the next frame start
        i_mole = 9'h101;
        show(500, 380, 1, 12'h000, "latch_before");
        pulse_frame();
        show(500, 380, 1, 12'h0F0, "latch_after");

        // Hit flash on hole 0, with a rejected re-hit at frame 10
        hit(9'h001, 0, 9'h001, "hit0_accept");
        tick();
        check("hit0_one_clk", o_hit_accepted, '0);
        show(120, 80, 1, 12'hFF0, "flash_start");
        for (int f = 1; f <= FF; f++) begin
            if (f == 10) hit(9'h001, 0, 9'h000, "hit0_rehit");
            pulse_frame();
            show(120, 80, 1, (f < FF) ? 12'hFF0 : 12'h0F0, $sformatf("flash_f%0d", f));
        end

        // Rejected hits: mole down, and centre hole
        hit(9'h004, 0, 9'h000, "reject_down");
        show(470, 80, 1, 12'h000, "reject_down_col");
        i_mole = 9'h111;
        pulse_frame();
        hit(9'h010, 0, 9'h000, "reject_centre");
        show(320, 240, 1, 12'h00F, "centre_stays");

        // Hit in the same clock as a frame start: load wins
        i_mole = 9'h1A3;
        pulse_frame();
        hit(9'h020, 1, 9'h020, "hit5_with_frame");
        for (int f = 1; f <= FF; f++) begin
            pulse_frame();
            show(470, 210, 1, (f < FF) ? 12'hFF0 : 12'h0F0, $sformatf("h5_f%0d", f));
        end

        // Independent hits on holes 1 and 7
        hit(9'h082, 0, 9'h082, "hit_1_7");

        // Reset while hole 1 is flashing
        pulse_frame();
        rst_n = 1'b0;
        tick();
        tick();
        check("midrst_rgb", {VGA_R, VGA_G, VGA_B}, 12'h000);
        check("midrst_acc", o_hit_accepted, '0);
        rst_n = 1'b1;
        show(300, 80, 1, 12'h000, "post_rst_black");
        pulse_frame();
        show(300, 80, 1, 12'h0F0, "post_rst_mole");

        // Randomized run against the model
        for (int n = 0; n < 4000; n++) begin
            rst_n         = ($urandom_range(0, 599) != 0);
            i_pix_stb     = $urandom_range(0, 1) == 1;
            i_x           = 10'($urandom_range(0, 639));
            i_y           = 9'($urandom_range(0, 479));
            i_active      = ($urandom_range(0, 7) != 0);
            i_frame_start = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 99) == 0) i_mole = N'($urandom);
            i_hit         = N'($urandom & $urandom & $urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
